spi_sclk_gen: RTL and testbench

//  SPI master serial-clock generator; first consumer of the testbench clk/rst source.

---
 rtl/spi_pkg.sv | 12 +
 rtl/spi_tick_cnt.sv | 27 ++
 rtl/spi_sclk_gen.sv | 184 ++++++++++++++++++
 tb/tb_spi_sclk_gen.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and default widths for the SPI serial-clock generator.
package spi_pkg;
  localparam int DEF_DIV_W = 8;
  localparam int DEF_CNT_W = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    RUN   = 2'd2,
    HOLD  = 2'd3
  } sclk_state_e;
endpackage

// File: rtl/spi_tick_cnt.sv
// Loadable down-counter: tick is high while the count sits at zero, so a load
// of N produces a tick N cycles later (N==0 gives a tick every cycle).
module spi_tick_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tick
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign tick = (cnt == '0);

endmodule

// File: rtl/spi_sclk_gen.sv
// SPI master serial-clock generator: one transfer of nbits bits with CPOL/CPHA,
// registered sclk and single-cycle shift/sample strobes aligned to sclk edges.
module spi_sclk_gen
  import spi_pkg::*;
#(
  parameter int DIV_W = DEF_DIV_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             cpol,
  input  logic             cpha,
  input  logic [DIV_W-1:0] div,
  input  logic [CNT_W-1:0] nbits,
  output logic             sclk,
  output logic             busy,
  output logic             done,
  output logic             shift_en,
  output logic             sample_en,
  output logic [CNT_W-1:0] bit_idx,
  output logic [1:0]       state
);

  // Handshake: start is sampled on a posedge only when busy==0 and done==0;
  // busy rises the cycle after acceptance and falls in the done cycle.

  sclk_state_e      state_q, state_d;
  logic             sclk_q, sclk_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             shift_q, shift_d;
  logic             sample_q, sample_d;
  logic [CNT_W-1:0] bit_idx_q, bit_idx_d;
  logic [CNT_W:0]   edge_q, edge_d;
  logic             cpol_q, cpol_d;
  logic             cpha_q, cpha_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] nbits_q, nbits_d;

  logic             load;
  logic [DIV_W-1:0] load_val;
  logic             tick;
  logic             do_edge;
  logic             leading;
  logic [CNT_W:0]   edge_next;
  logic [CNT_W:0]   last_edge;

  spi_tick_cnt #(.W(DIV_W)) u_tick (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (load_val),
    .tick     (tick)
  );

  assign edge_next = edge_q + (CNT_W+1)'(1);
  assign last_edge = {nbits_q, 1'b0};
  assign leading   = edge_next[0];

  always_comb begin
    state_d   = state_q;
    sclk_d    = sclk_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    shift_d   = 1'b0;
    sample_d  = 1'b0;
    bit_idx_d = bit_idx_q + CNT_W'(sample_q);
    edge_d    = edge_q;
    cpol_d    = cpol_q;
    cpha_d    = cpha_q;
    div_d     = div_q;
    nbits_d   = nbits_q;
    load      = 1'b0;
    load_val  = div_q;
    do_edge   = 1'b0;

    if (abort) begin
      state_d = IDLE;
      busy_d  = 1'b0;
      sclk_d  = cpol_q;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && !done_q && (nbits != '0)) begin
            state_d   = SETUP;
            busy_d    = 1'b1;
            sclk_d    = cpol;
            shift_d   = !cpha;
            bit_idx_d = '0;
            edge_d    = '0;
            cpol_d    = cpol;
            cpha_d    = cpha;
            div_d     = div;
            nbits_d   = nbits;
            load      = 1'b1;
            load_val  = div;
          end
        end
        SETUP: begin
          if (tick) begin
            state_d = RUN;
            load    = 1'b1;
            do_edge = 1'b1;
          end
        end
        RUN: begin
          // The tick after the final trailing edge closes its half-period.
          if (tick) begin
            load = 1'b1;
            if (edge_q == last_edge) begin
              state_d = HOLD;
            end else begin
              do_edge = 1'b1;
            end
          end
        end
        HOLD: begin
          if (tick) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      endcase

      if (do_edge) begin
        edge_d = edge_next;
        sclk_d = leading ? ~cpol_q : cpol_q;
        if (cpha_q) begin
          shift_d  = leading;
          sample_d = !leading;
        end else begin
          sample_d = leading;
          shift_d  = !leading && (edge_next != last_edge);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      sclk_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      shift_q   <= 1'b0;
      sample_q  <= 1'b0;
      bit_idx_q <= '0;
      edge_q    <= '0;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      div_q     <= '0;
      nbits_q   <= '0;
    end else begin
      state_q   <= state_d;
      sclk_q    <= sclk_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      shift_q   <= shift_d;
      sample_q  <= sample_d;
      bit_idx_q <= bit_idx_d;
      edge_q    <= edge_d;
      cpol_q    <= cpol_d;
      cpha_q    <= cpha_d;
      div_q     <= div_d;
      nbits_q   <= nbits_d;
    end
  end

  assign sclk      = sclk_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign shift_en  = shift_q;
  assign sample_en = sample_q;
  assign bit_idx   = bit_idx_q;
  assign state     = state_q;

endmodule

// File: tb/tb_spi_sclk_gen.sv
// Bench for spi_sclk_gen: every expected strobe/done event is predicted with its
// cycle number and sclk level, queued at start, and matched as the DUT emits it.
module tb_spi_sclk_gen;

  localparam logic [1:0] K_SHIFT  = 2'd1;
  localparam logic [1:0] K_SAMPLE = 2'd2;
  localparam logic [1:0] K_DONE   = 2'd3;

  logic       clk;
  logic       rst;
  logic       start;
  logic       abort;
  logic       cpol;
  logic       cpha;
  logic [7:0] div;
  logic [5:0] nbits;
  logic       sclk;
  logic       busy;
  logic       done;
  logic       shift_en;
  logic       sample_en;
  logic [5:0] bit_idx;
  logic [1:0] state;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [31:0] exp_q[$];

  spi_sclk_gen #(.DIV_W(8), .CNT_W(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .cpol      (cpol),
    .cpha      (cpha),
    .div       (div),
    .nbits     (nbits),
    .sclk      (sclk),
    .busy      (busy),
    .done      (done),
    .shift_en  (shift_en),
    .sample_en (sample_en),
    .bit_idx   (bit_idx),
    .state     (state)
  );

  // Clock / cycle counter: outputs of cycle N are sampled at the negedge with cyc==N.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ev(input logic [1:0] kind, input logic s, input int c);
    return {kind, s, c[28:0]};
  endfunction

  task automatic pop_cmp(input string tag, input logic [31:0] obs);
    if (exp_q.size() == 0) check(tag, obs, 32'h0);
    else check(tag, obs, exp_q.pop_front());
  endtask

  // Reference timeline of one transfer accepted in cycle t.
  task automatic plan(input int t, input int d, input int n, input logic pol, input logic pha);
    int  c;
    logic lead;
    if (!pha) exp_q.push_back(ev(K_SHIFT, pol, t + 1));
    for (int k = 1; k <= 2 * n; k++) begin
      lead = (k % 2) == 1;
      c    = t + 1 + k * (d + 1);
      if (pha) exp_q.push_back(ev(lead ? K_SHIFT : K_SAMPLE, lead ? ~pol : pol, c));
      else if (lead) exp_q.push_back(ev(K_SAMPLE, ~pol, c));
      else if (k != 2 * n) exp_q.push_back(ev(K_SHIFT, pol, c));
    end
    exp_q.push_back(ev(K_DONE, pol, t + 1 + (2 * n + 2) * (d + 1)));
  endtask

  // Monitor: every strobe/done must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst) begin
      if (shift_en)  pop_cmp("shift_ev",  ev(K_SHIFT,  sclk, cyc));
      if (sample_en) pop_cmp("sample_ev", ev(K_SAMPLE, sclk, cyc));
      if (done)      pop_cmp("done_ev",   ev(K_DONE,   sclk, cyc));
    end
  end

  // Driver: called at a negedge; holds start for one cycle.
  task automatic do_start(input int d, input int n, input logic pol, input logic pha,
                          input logic acc, input logic exp_busy);
    int t;
    t     = cyc;
    div   = d[7:0];
    nbits = n[5:0];
    cpol  = pol;
    cpha  = pha;
    start = 1'b1;
    if (acc) plan(t, d, n, pol, pha);
    @(negedge clk);
    start = 1'b0;
    check("busy_t1", busy, exp_busy);
  endtask

  task automatic wait_done(input int n_exp, input logic pol);
    int k;
    k = 0;
    while (!done && k < 500) begin
      @(negedge clk);
      k++;
    end
    if (!done) begin
      check("done_timeout", 32'd0, 32'd1);
    end else begin
      check("bit_idx_done", bit_idx, n_exp);
      check("busy_done", busy, 1'b0);
      check("sclk_done", sclk, pol);
    end
  endtask

  initial begin
    int k;
    int c_ab;
    logic [31:0] last;

    rst = 1'b0; start = 1'b0; abort = 1'b0;
    cpol = 1'b0; cpha = 1'b0; div = '0; nbits = '0;
    repeat (3) @(negedge clk);
    check("rst_sclk", sclk, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_strobes", {shift_en, sample_en}, 2'b00);
    check("rst_bit_idx", bit_idx, 6'd0);
    check("rst_state", state, 2'd0);
    rst = 1'b1;
    @(negedge clk);

    // Asynchronous reset in the middle of RUN while sclk sits at cpol=1.
    do_start(2, 4, 1'b1, 1'b0, 1'b1, 1'b1);
    repeat (12) @(negedge clk);
    check("pre_rst_sclk", sclk, 1'b1);
    #2 rst = 1'b0;
    #1;
    check("midrst_sclk", sclk, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_strobes", {shift_en, sample_en, done}, 3'b000);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    check("post_rst_busy", busy, 1'b0);

    // Mode 0.
    do_start(1, 8, 1'b0, 1'b0, 1'b1, 1'b1);
    wait_done(8, 1'b0);
    @(negedge clk);

    // Mode 3 with div 0.
    check("sclk_idle0", sclk, 1'b0);
    do_start(0, 4, 1'b1, 1'b1, 1'b1, 1'b1);
    check("sclk_setup3", sclk, 1'b1);
    wait_done(4, 1'b1);
    repeat (2) @(negedge clk);
    check("sclk_idle1", sclk, 1'b1);

    // Abort on the 5th sample strobe.
    do_start(3, 16, 1'b0, 1'b0, 1'b1, 1'b1);
    k = 0;
    for (int i = 0; i < 400 && k < 5; i++) begin
      @(negedge clk);
      if (sample_en) k++;
    end
    check("abort_reach5", k, 5);
    c_ab  = cyc;
    abort = 1'b1;
    while (exp_q.size() > 0) begin
      last = exp_q[exp_q.size() - 1];
      if (last[28:0] > c_ab[28:0]) exp_q.pop_back();
      else break;
    end
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_sclk", sclk, 1'b0);
    check("abort_outs", {shift_en, sample_en, done}, 3'b000);
    check("abort_state", state, 2'd0);
    repeat (100) @(negedge clk);
    do_start(0, 2, 1'b0, 1'b1, 1'b1, 1'b1);
    wait_done(2, 1'b0);
    @(negedge clk);

    // Busy guard: foreign starts while busy, then a zero-length request.
    do_start(2, 3, 1'b0, 1'b1, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    do_start(0, 7, 1'b1, 1'b0, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    do_start(5, 1, 1'b1, 1'b1, 1'b0, 1'b1);
    wait_done(3, 1'b0);
    @(negedge clk);
    do_start(1, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    check("nb0_busy", busy, 1'b0);
    check("nb0_sclk", sclk, 1'b0);

    // Back-to-back: start in the done cycle is dropped, one cycle later accepted.
    do_start(0, 2, 1'b0, 1'b0, 1'b1, 1'b1);
    wait_done(2, 1'b0);
    do_start(4, 3, 1'b1, 1'b1, 1'b0, 1'b0);
    do_start(1, 2, 1'b1, 1'b0, 1'b1, 1'b1);
    wait_done(2, 1'b1);

    repeat (5) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
